// File: rtl/ioram_rd_agen.sv
// Read-address generator for ioram: walks a rows x cols tile from a base address
// with a row stride, repeated for a number of passes, one address per valid/ready beat.
module ioram_rd_agen #(
    parameter int AW = 14,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW-1:0] cfg_stride,
    input  logic [CW-1:0] cfg_cols,
    input  logic [CW-1:0] cfg_rows,
    input  logic [CW-1:0] cfg_passes,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] r_addr,
    output logic          r_addr_first,
    output logic          r_addr_last,
    output logic          r_addr_valid,
    input  logic          r_addr_ready,
    output logic [1:0]    dbg_state
);

    // Handshake: a beat transfers on a rising edge where r_addr_valid && r_addr_ready;
    // while valid is high and ready low, r_addr and its flags are held unchanged.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] base_q, stride_q, row_base;
    logic [CW-1:0] cols_q, rows_q, passes_q;
    logic [CW-1:0] col, row, pass;

    logic          hs, col_wrap, row_wrap, cfg_zero, cfg_single, nxt_last;
    logic [CW-1:0] nxt_col, nxt_row, nxt_pass;
    logic [AW-1:0] nxt_row_base;

    assign dbg_state = state;

    always_comb begin
        hs           = r_addr_valid && r_addr_ready;
        col_wrap     = (col == cols_q - CW'(1));
        row_wrap     = (row == rows_q - CW'(1));
        nxt_col      = col_wrap ? '0 : col + CW'(1);
        nxt_row      = row;
        nxt_pass     = pass;
        nxt_row_base = row_base;
        if (col_wrap) begin
            if (row_wrap) begin
                nxt_row      = '0;
                nxt_pass     = pass + CW'(1);
                nxt_row_base = base_q;
            end else begin
                nxt_row      = row + CW'(1);
                nxt_row_base = row_base + stride_q;
            end
        end
        nxt_last   = (nxt_pass == passes_q - CW'(1)) && (nxt_row == rows_q - CW'(1)) &&
                     (nxt_col == cols_q - CW'(1));
        cfg_zero   = (cfg_cols == '0) || (cfg_rows == '0) || (cfg_passes == '0);
        cfg_single = (cfg_cols == CW'(1)) && (cfg_rows == CW'(1)) && (cfg_passes == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            base_q       <= '0;
            stride_q     <= '0;
            cols_q       <= '0;
            rows_q       <= '0;
            passes_q     <= '0;
            col          <= '0;
            row          <= '0;
            pass         <= '0;
            row_base     <= '0;
            r_addr       <= '0;
            r_addr_first <= 1'b0;
            r_addr_last  <= 1'b0;
            r_addr_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= cfg_base;
                        stride_q <= cfg_stride;
                        cols_q   <= cfg_cols;
                        rows_q   <= cfg_rows;
                        passes_q <= cfg_passes;
                        col      <= '0;
                        row      <= '0;
                        pass     <= '0;
                        row_base <= cfg_base;
                        if (cfg_zero) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state        <= S_RUN;
                            r_addr       <= cfg_base;
                            r_addr_valid <= 1'b1;
                            r_addr_first <= 1'b1;
                            r_addr_last  <= cfg_single;
                            busy         <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        r_addr_first <= 1'b0;
                        if (r_addr_last) begin
                            r_addr_valid <= 1'b0;
                            r_addr_last  <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= S_FIN;
                        end else begin
                            col         <= nxt_col;
                            row         <= nxt_row;
                            pass        <= nxt_pass;
                            row_base    <= nxt_row_base;
                            r_addr      <= nxt_row_base + AW'(nxt_col);
                            r_addr_last <= nxt_last;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioram_rd_agen.sv
// Randomized bench for ioram_rd_agen: a loop-based tile model fills an expected
// beat queue; a negedge monitor checks every handshake and hold behaviour.
module tb_ioram_rd_agen;

    localparam int AW = 14;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cfg_base, cfg_stride;
    logic [CW-1:0] cfg_cols, cfg_rows, cfg_passes;
    logic          start;
    logic          busy, done;
    logic [AW-1:0] r_addr;
    logic          r_addr_first, r_addr_last, r_addr_valid;
    logic          r_addr_ready = 1'b0;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    ioram_rd_agen #(.AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride),
        .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_passes(cfg_passes),
        .start(start), .busy(busy), .done(done),
        .r_addr(r_addr), .r_addr_first(r_addr_first), .r_addr_last(r_addr_last),
        .r_addr_valid(r_addr_valid), .r_addr_ready(r_addr_ready),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ready pattern: 0 = always high, 1 = alternating, 2 = random stalls
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       r_addr_ready = 1'b1;
            1:       r_addr_ready = ~r_addr_ready;
            default: r_addr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard: {first, last, addr} per beat
    logic [AW+1:0] exp_q[$];
    int            cyc_cnt = 0;
    int            last_hs_cyc = 0;
    int            hs_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [AW+1:0] prev_beat = '0;

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        logic [AW+1:0] e;
        if (!rst) begin
            if (prev_stall)
                check("hold", 32'({r_addr_valid, r_addr_first, r_addr_last, r_addr}),
                      32'({1'b1, prev_beat}));
            if (r_addr_valid && r_addr_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'({r_addr_first, r_addr_last, r_addr}), 32'(e));
                    if (e[AW]) last_hs_cyc = cyc_cnt;
                end
            end
            prev_stall = r_addr_valid && !r_addr_ready;
            prev_beat  = {r_addr_first, r_addr_last, r_addr};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic build_expect(input logic [AW-1:0] b, input logic [AW-1:0] s,
                                input int c, input int r, input int p);
        logic [AW-1:0] a;
        for (int pi = 0; pi < p; pi++)
            for (int ri = 0; ri < r; ri++)
                for (int ci = 0; ci < c; ci++) begin
                    a = AW'(32'(b) + ri * 32'(s) + ci);
                    exp_q.push_back({(pi == 0 && ri == 0 && ci == 0),
                                     (pi == p - 1 && ri == r - 1 && ci == c - 1), a});
                end
    endtask

    task automatic scramble_cfg();
        cfg_base   = AW'($urandom);
        cfg_stride = AW'($urandom);
        cfg_cols   = CW'($urandom_range(1, 9));
        cfg_rows   = CW'($urandom_range(1, 9));
        cfg_passes = CW'($urandom_range(1, 9));
    endtask

    task automatic issue_start(input logic [AW-1:0] b, input logic [AW-1:0] s,
                               input logic [CW-1:0] c, input logic [CW-1:0] r,
                               input logic [CW-1:0] p);
        @(posedge clk);
        #1;
        cfg_base = b; cfg_stride = s; cfg_cols = c; cfg_rows = r; cfg_passes = p;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_cfg();
    endtask

    task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] s,
                           input logic [CW-1:0] c, input logic [CW-1:0] r,
                           input logic [CW-1:0] p, input bit mid_start);
        int total, cyc;
        bit got;
        total = int'(c) * int'(r) * int'(p);
        build_expect(b, s, int'(c), int'(r), int'(p));
        issue_start(b, s, c, r, p);
        got = 1'b0;
        for (cyc = 0; cyc < total * 20 + 20; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check("first_valid", 32'(r_addr_valid), 32'(total != 0));
            if (total == 0) check("zero_job_idle", 32'({busy, r_addr_valid}), 32'd0);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (total != 0) check("busy", 32'(busy), 32'd1);
            if (mid_start && cyc == 2) begin
                start = 1'b1;
                scramble_cfg();
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            if (total == 0) check("zero_done_lat", 32'(cyc), 32'd0);
            else            check("done_lat", 32'(cyc_cnt), 32'(last_hs_cyc + 1));
            check("fin_idle", 32'({busy, r_addr_valid}), 32'd0);
            check("beats_left", 32'(exp_q.size()), 32'd0);
            start = 1'b1;
            scramble_cfg();
            @(negedge clk);
            start = 1'b0;
            check("done_width", 32'(done), 32'd0);
            check("fin_start_ignored", 32'({busy, r_addr_valid}), 32'd0);
        end
        exp_q.delete();
    endtask

    task automatic reset_mid_job();
        int hs0;
        ready_mode = 0;
        build_expect(14'h100, 14'h10, 3, 2, 1);
        hs0 = hs_cnt;
        issue_start(14'h100, 14'h10, 8'd3, 8'd2, 8'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hs_cnt - hs0 >= 3) break;
        end
        check("pre_reset_beats", 32'(hs_cnt - hs0 >= 3), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ctrl", 32'({r_addr_valid, busy, done, r_addr_first, r_addr_last}), 32'd0);
        check("rst_addr", 32'(r_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_done", 32'({done, busy, r_addr_valid}), 32'd0);
    endtask

    initial begin
        int c, r, p;
        rst = 1'b1;
        start = 1'b0;
        cfg_base = '0; cfg_stride = '0; cfg_cols = '0; cfg_rows = '0; cfg_passes = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 32'({busy, done, r_addr_valid, r_addr_first, r_addr_last}), 32'd0);
        check("reset_addr", 32'(r_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'({busy, done, r_addr_valid}), 32'd0);

        ready_mode = 0; run_job(14'h100, 14'h10, 8'd3, 8'd2, 8'd1, 1'b0);
        ready_mode = 1; run_job(14'h100, 14'h10, 8'd3, 8'd2, 8'd1, 1'b0);
        ready_mode = 2; run_job(14'h100, 14'h10, 8'd3, 8'd2, 8'd1, 1'b1);
        ready_mode = 0;
        run_job(14'h3FFE, 14'h2, 8'd4, 8'd2, 8'd1, 1'b0);
        run_job(14'h20, 14'h8, 8'd2, 8'd2, 8'd2, 1'b0);
        run_job(14'h55, 14'h3, 8'd1, 8'd1, 8'd1, 1'b0);
        run_job(14'h40, 14'h4, 8'd2, 8'd0, 8'd3, 1'b0);
        run_job(14'h40, 14'h4, 8'd0, 8'd2, 8'd3, 1'b0);
        run_job(14'h40, 14'h4, 8'd2, 8'd2, 8'd0, 1'b0);

        reset_mid_job();
        run_job(14'h100, 14'h10, 8'd3, 8'd2, 8'd1, 1'b1);

        for (int j = 0; j < 14; j++) begin
            ready_mode = $urandom_range(0, 2);
            c = $urandom_range(0, 4);
            r = $urandom_range(1, 3);
            p = $urandom_range(1, 3);
            run_job(AW'($urandom), AW'($urandom), CW'(c), CW'(r), CW'(p), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
